// File: rtl/ray_issue_arb.sv
// Two-requester ray issue arbiter: secondary rays win unless a waiting primary
// ray has been passed over MAX_SEC_BURST times; counts primary issues per frame.
module ray_issue_arb #(
  parameter int unsigned WIDTH         = 211,
  parameter int unsigned MAX_SEC_BURST = 8,
  parameter int unsigned NUM_PRIM      = 307200
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             prim_valid,
  input  logic [WIDTH-1:0] prim_data,
  output logic             prim_stall,
  input  logic             sec_valid,
  input  logic [WIDTH-1:0] sec_data,
  output logic             sec_stall,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  output logic             out_is_sec,
  input  logic             out_stall,
  output logic             frame_done
);

  localparam logic [7:0]  BURST_MAX = 8'(MAX_SEC_BURST);
  localparam logic [18:0] LAST_PRIM = 19'(NUM_PRIM - 1);

  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic             out_is_sec_q, out_is_sec_d;
  logic             frame_done_q, frame_done_d;
  logic [7:0]       burst_cnt_q, burst_cnt_d;
  logic [18:0]      prim_cnt_q, prim_cnt_d;

  logic load, xfer, burst_full;
  logic sel_prim, sel_sec, grant_prim, grant_sec;

  assign load       = ~out_valid_q | ~out_stall;
  assign xfer       = out_valid_q & ~out_stall;
  assign burst_full = (burst_cnt_q == BURST_MAX);

  // sel_* mean "this requester would be taken if it offers", so an idle
  // requester sees no stall while the register can load.
  assign sel_sec    = ~(prim_valid & burst_full);
  assign sel_prim   = ~(sec_valid & ~burst_full);
  assign grant_sec  = load & sec_valid & sel_sec;
  assign grant_prim = load & prim_valid & sel_prim;

  assign prim_stall = ~(load & sel_prim);
  assign sec_stall  = ~(load & sel_sec);

  always_comb begin
    out_valid_d  = out_valid_q;
    out_data_d   = out_data_q;
    out_is_sec_d = out_is_sec_q;
    burst_cnt_d  = burst_cnt_q;
    prim_cnt_d   = prim_cnt_q;
    frame_done_d = 1'b0;

    if (grant_sec || grant_prim) begin
      out_valid_d  = 1'b1;
      out_data_d   = grant_sec ? sec_data : prim_data;
      out_is_sec_d = grant_sec;
    end else if (xfer) begin
      out_valid_d  = 1'b0;
    end

    if (!prim_valid || grant_prim) begin
      burst_cnt_d = '0;
    end else if (grant_sec && !burst_full) begin
      burst_cnt_d = burst_cnt_q + 8'd1;
    end

    if (xfer && !out_is_sec_q) begin
      if (prim_cnt_q == LAST_PRIM) begin
        prim_cnt_d   = '0;
        frame_done_d = 1'b1;
      end else begin
        prim_cnt_d   = prim_cnt_q + 19'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q  <= 1'b0;
      out_data_q   <= '0;
      out_is_sec_q <= 1'b0;
      frame_done_q <= 1'b0;
      burst_cnt_q  <= '0;
      prim_cnt_q   <= '0;
    end else begin
      out_valid_q  <= out_valid_d;
      out_data_q   <= out_data_d;
      out_is_sec_q <= out_is_sec_d;
      frame_done_q <= frame_done_d;
      burst_cnt_q  <= burst_cnt_d;
      prim_cnt_q   <= prim_cnt_d;
    end
  end

  assign out_valid  = out_valid_q;
  assign out_data   = out_data_q;
  assign out_is_sec = out_is_sec_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_ray_issue_arb.sv
// Directed bench for ray_issue_arb with NUM_PRIM=4 and MAX_SEC_BURST=8.
module tb_ray_issue_arb;
  localparam int unsigned W = 211;

  logic         clk = 1'b0;
  logic         rst;
  logic         prim_valid, sec_valid, out_stall;
  logic [W-1:0] prim_data, sec_data;
  logic         prim_stall, sec_stall, out_valid, out_is_sec, frame_done;
  logic [W-1:0] out_data;

  int n_cmp = 0;
  int n_bad = 0;

  ray_issue_arb #(.WIDTH(W), .MAX_SEC_BURST(8), .NUM_PRIM(4)) dut (
    .clk(clk), .rst(rst),
    .prim_valid(prim_valid), .prim_data(prim_data), .prim_stall(prim_stall),
    .sec_valid(sec_valid), .sec_data(sec_data), .sec_stall(sec_stall),
    .out_valid(out_valid), .out_data(out_data), .out_is_sec(out_is_sec),
    .out_stall(out_stall), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic offer(input logic pv, input logic [W-1:0] pd, input logic sv, input logic [W-1:0] sd);
    prim_valid = pv; prim_data = pd; sec_valid = sv; sec_data = sd;
  endtask

  task automatic do_reset();
    rst = 1'b1; out_stall = 1'b0;
    offer(1'b0, '0, 1'b0, '0);
    tick(); tick();
    rst = 1'b0;
  endtask

  initial begin
    do_reset();
    #1;
    check_val("rst_out_valid", out_valid, 0);
    check_val("rst_out_data", out_data, 0);
    check_val("rst_out_is_sec", out_is_sec, 0);
    check_val("rst_frame_done", frame_done, 0);
    check_val("rst_burst", dut.burst_cnt_q, 0);
    check_val("rst_prim_cnt", dut.prim_cnt_q, 0);
    check_val("rst_prim_stall", prim_stall, 0);
    check_val("rst_sec_stall", sec_stall, 0);

    // primary-only stream, one ray per cycle
    do_reset();
    for (int i = 0; i < 3; i++) begin
      offer(1'b1, W'(100 + i), 1'b0, '0);
      #1;
      check_val("prim_only_stall", prim_stall, 0);
      tick();
      check_val("prim_only_valid", out_valid, 1);
      check_val("prim_only_data", out_data, W'(100 + i));
      check_val("prim_only_is_sec", out_is_sec, 0);
    end
    offer(1'b0, '0, 1'b0, '0);
    tick();
    check_val("prim_only_drain_valid", out_valid, 0);
    check_val("prim_only_cnt", dut.prim_cnt_q, 3);

    // both continuously valid: 8 secondary then 1 primary, repeating
    do_reset();
    for (int k = 0; k < 18; k++) begin
      logic exp_sec;
      exp_sec = ((k % 9) != 8);
      offer(1'b1, W'('hA000 + k), 1'b1, W'('h5000 + k));
      #1;
      check_val("burst_prim_stall", prim_stall, exp_sec);
      check_val("burst_sec_stall", sec_stall, !exp_sec);
      tick();
      check_val("burst_is_sec", out_is_sec, exp_sec);
      check_val("burst_data", out_data, exp_sec ? W'('h5000 + k) : W'('hA000 + k));
      check_val("burst_cnt", dut.burst_cnt_q, exp_sec ? W'((k % 9) + 1) : W'(0));
    end

    // output stalled for 5 cycles holds data, then replaced with no bubble
    do_reset();
    offer(1'b1, W'('h77), 1'b0, '0);
    tick();
    check_val("stall_load", out_data, W'('h77));
    out_stall = 1'b1;
    for (int i = 0; i < 5; i++) begin
      offer(1'b1, W'('h88 + i), 1'b1, W'('h99 + i));
      #1;
      check_val("stall_prim_stall", prim_stall, 1);
      check_val("stall_sec_stall", sec_stall, 1);
      tick();
      check_val("stall_hold_data", out_data, W'('h77));
      check_val("stall_hold_valid", out_valid, 1);
    end
    offer(1'b1, W'('h88), 1'b1, W'('h99));
    out_stall = 1'b0;
    #1;
    check_val("release_sec_stall", sec_stall, 0);
    check_val("release_prim_stall", prim_stall, 1);
    tick();
    check_val("release_data", out_data, W'('h99));
    check_val("release_is_sec", out_is_sec, 1);
    check_val("release_prim_cnt", dut.prim_cnt_q, 1);

    // frame: P S P S P S P, frame_done one cycle after 4th primary transfer
    do_reset();
    for (int k = 1; k <= 9; k++) begin
      if (k <= 7) offer(k % 2 == 1, W'('h100 + k), k % 2 == 0, W'('h200 + k));
      else offer(1'b0, '0, 1'b0, '0);
      tick();
      check_val("frame_done_pulse", frame_done, k == 8);
      if (k == 7) check_val("frame_cnt_before", dut.prim_cnt_q, 3);
      if (k == 8) check_val("frame_cnt_wrap", dut.prim_cnt_q, 0);
    end

    // reset mid-operation with burst_cnt = 5
    do_reset();
    for (int k = 0; k < 5; k++) begin
      offer(1'b1, W'('h300 + k), 1'b1, W'('h400 + k));
      tick();
    end
    check_val("midrst_burst_pre", dut.burst_cnt_q, 5);
    check_val("midrst_valid_pre", out_valid, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_val("midrst_valid", out_valid, 0);
    check_val("midrst_data", out_data, 0);
    check_val("midrst_burst", dut.burst_cnt_q, 0);
    check_val("midrst_prim_cnt", dut.prim_cnt_q, 0);
    offer(1'b1, W'('h42), 1'b0, '0);
    #1;
    check_val("midrst_prim_stall", prim_stall, 0);
    tick();
    check_val("midrst_first_valid", out_valid, 1);
    check_val("midrst_first_data", out_data, W'('h42));
    check_val("midrst_first_is_sec", out_is_sec, 0);

    // prim_valid drop clears burst; then 8 more secondaries before primary
    do_reset();
    for (int k = 0; k < 3; k++) begin
      offer(1'b1, W'('h500), 1'b1, W'('h600 + k));
      tick();
    end
    check_val("drop_burst_pre", dut.burst_cnt_q, 3);
    offer(1'b0, '0, 1'b1, W'('h6FF));
    tick();
    check_val("drop_burst_clear", dut.burst_cnt_q, 0);
    for (int k = 0; k < 9; k++) begin
      offer(1'b1, W'('h700 + k), 1'b1, W'('h800 + k));
      tick();
      check_val("drop_is_sec", out_is_sec, k < 8);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
